// File: rtl/rename_table_pkg.sv
// Shared sizing and map-entry type for the register rename table.
package rename_table_pkg;
  localparam int REG_NUM     = 32;
  localparam int REG_SEL     = 5;
  localparam int PHY_REG_NUM = 64;
  localparam int PHY_REG_SEL = $clog2(PHY_REG_NUM);
  localparam int NUM_SLOTS   = 2;
  localparam int NUM_SRC     = 4;

  typedef struct packed {
    logic                   valid;
    logic [PHY_REG_SEL-1:0] tag;
  } map_entry_t;
endpackage

// File: rtl/rename_table_if.sv
// Dispatch-side bundle of the rename table: freelist inputs, commit inputs, renamed outputs.
interface rename_table_if;
  import rename_table_pkg::*;

  logic                   invalid1, invalid2, wr_reg_1, wr_reg_2;
  logic [REG_SEL-1:0]     src1_1, src2_1, src1_2, src2_2, dst1, dst2;
  logic [PHY_REG_SEL-1:0] phy_dst1, phy_dst2;
  logic                   phy_dst1_valid, phy_dst2_valid, allocatable;
  logic                   stall_DP, prmiss;
  logic                   com_valid1, com_valid2;
  logic [REG_SEL-1:0]     com_dst1, com_dst2;
  logic [PHY_REG_SEL-1:0] com_phy1, com_phy2;

  logic                   rn_valid1, rn_valid2;
  logic [PHY_REG_SEL-1:0] rn_phy_dst1, rn_phy_dst2;
  logic [PHY_REG_SEL-1:0] rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2;
  logic                   rn_src1_1_mapped, rn_src2_1_mapped, rn_src1_2_mapped, rn_src2_2_mapped;
  logic [PHY_REG_SEL-1:0] rn_old1, rn_old2;
  logic                   rn_old1_valid, rn_old2_valid;

  modport slave (
    input  invalid1, invalid2, wr_reg_1, wr_reg_2, src1_1, src2_1, src1_2, src2_2,
           dst1, dst2, phy_dst1, phy_dst2, phy_dst1_valid, phy_dst2_valid, allocatable,
           stall_DP, prmiss, com_valid1, com_valid2, com_dst1, com_dst2, com_phy1, com_phy2,
    output rn_valid1, rn_valid2, rn_phy_dst1, rn_phy_dst2,
           rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2,
           rn_src1_1_mapped, rn_src2_1_mapped, rn_src1_2_mapped, rn_src2_2_mapped,
           rn_old1, rn_old2, rn_old1_valid, rn_old2_valid
  );

  modport master (
    output invalid1, invalid2, wr_reg_1, wr_reg_2, src1_1, src2_1, src1_2, src2_2,
           dst1, dst2, phy_dst1, phy_dst2, phy_dst1_valid, phy_dst2_valid, allocatable,
           stall_DP, prmiss, com_valid1, com_valid2, com_dst1, com_dst2, com_phy1, com_phy2,
    input  rn_valid1, rn_valid2, rn_phy_dst1, rn_phy_dst2,
           rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2,
           rn_src1_1_mapped, rn_src2_1_mapped, rn_src1_2_mapped, rn_src2_2_mapped,
           rn_old1, rn_old2, rn_old1_valid, rn_old2_valid
  );
endinterface

// File: rtl/rename_map_bank.sv
// REG_NUM x {valid,tag} map: NRD async read ports, two write ports (port 2 wins), whole-map load.
module rename_map_bank
  import rename_table_pkg::*;
#(
  parameter int NRD = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic       [1:0]                  we,
  input  logic       [1:0][REG_SEL-1:0]     wa,
  input  map_entry_t [1:0]                  wd,
  input  logic                              ld,
  input  map_entry_t [REG_NUM-1:0]          ld_map,
  input  logic       [NRD-1:0][REG_SEL-1:0] ra,
  output map_entry_t [NRD-1:0]              rd,
  output map_entry_t [REG_NUM-1:0]          map_q,
  output map_entry_t [REG_NUM-1:0]          map_nxt
);
  // Later port overwrites earlier one when both hit the same entry.
  always_comb begin
    map_nxt = map_q;
    if (ld) begin
      map_nxt = ld_map;
    end else begin
      for (int p = 0; p < 2; p++)
        if (we[p]) map_nxt[wa[p]] = wd[p];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) map_q <= '0;
    else       map_q <= map_nxt;
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign rd[r] = map_q[ra[r]];
  end
endmodule

// File: rtl/rename_table.sv
// Two-wide register rename: speculative map for dispatch, committed map for misprediction recovery.
module rename_table
  import rename_table_pkg::*;
(
  input logic           clk,
  input logic           reset,
  rename_table_if.slave rn
);
  logic                                fire;
  logic       [NUM_SLOTS-1:0]          slot_on, wr;
  logic       [NUM_SLOTS-1:0][REG_SEL-1:0]     dst;
  logic       [NUM_SLOTS-1:0][PHY_REG_SEL-1:0] pdst;
  logic       [NUM_SRC-1:0][REG_SEL-1:0]       src;
  map_entry_t [NUM_SRC-1:0]            sm_rd, src_n, src_q;
  map_entry_t [NUM_SLOTS-1:0]          sm_wd, cm_wd, old_n, old_q;
  map_entry_t [REG_NUM-1:0]            sm_q, cm_nxt;
  map_entry_t [REG_NUM-1:0]            sm_nxt_unused, cm_q_unused;
  map_entry_t [0:0]                    cm_rd_unused;
  logic       [NUM_SLOTS-1:0]          vld_q;
  logic       [NUM_SLOTS-1:0][PHY_REG_SEL-1:0] pdst_q;

  assign fire    = rn.allocatable & ~rn.stall_DP & ~rn.prmiss;
  assign slot_on = {rn.wr_reg_2 & ~rn.invalid2, rn.wr_reg_1 & ~rn.invalid1};
  assign wr      = slot_on & {rn.phy_dst2_valid, rn.phy_dst1_valid};
  assign dst     = {rn.dst2, rn.dst1};
  assign pdst    = {rn.phy_dst2, rn.phy_dst1};
  assign src     = {rn.src2_2, rn.src1_2, rn.src2_1, rn.src1_1};
  assign sm_wd   = {{1'b1, pdst[1]}, {1'b1, pdst[0]}};
  assign cm_wd   = {{1'b1, rn.com_phy2}, {1'b1, rn.com_phy1}};

  rename_map_bank #(.NRD(NUM_SRC)) u_sm (
    .clk     (clk),
    .reset   (reset),
    .we      (wr & {NUM_SLOTS{fire}}),
    .wa      (dst),
    .wd      (sm_wd),
    .ld      (rn.prmiss),
    .ld_map  (cm_nxt),
    .ra      (src),
    .rd      (sm_rd),
    .map_q   (sm_q),
    .map_nxt (sm_nxt_unused)
  );

  // Recovery copies the committed map's next state so same-cycle commits are included.
  rename_map_bank #(.NRD(1)) u_cm (
    .clk     (clk),
    .reset   (reset),
    .we      ({rn.com_valid2, rn.com_valid1}),
    .wa      ({rn.com_dst2, rn.com_dst1}),
    .wd      (cm_wd),
    .ld      (1'b0),
    .ld_map  ('0),
    .ra      ('0),
    .rd      (cm_rd_unused),
    .map_q   (cm_q_unused),
    .map_nxt (cm_nxt)
  );

  // Slot 2 sees slot 1's fresh tag for both sources and its previous mapping.
  always_comb begin
    src_n = sm_rd;
    for (int s = 2; s < NUM_SRC; s++)
      if (wr[0] && src[s] == dst[0]) src_n[s] = sm_wd[0];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      old_n[i]       = sm_q[dst[i]];
      old_n[i].valid = sm_q[dst[i]].valid & wr[i];
    end
    if (wr[0] && dst[1] == dst[0]) begin
      old_n[1].tag   = pdst[0];
      old_n[1].valid = wr[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      pdst_q <= '0;
      src_q  <= '0;
      old_q  <= '0;
    end else if (fire) begin
      vld_q  <= slot_on;
      pdst_q <= pdst;
      src_q  <= src_n;
      old_q  <= old_n;
    end else if (rn.prmiss || !rn.stall_DP) begin
      vld_q  <= '0;
    end
  end

  assign rn.rn_valid1        = vld_q[0];
  assign rn.rn_valid2        = vld_q[1];
  assign rn.rn_phy_dst1      = pdst_q[0];
  assign rn.rn_phy_dst2      = pdst_q[1];
  assign rn.rn_src1_1        = src_q[0].tag;
  assign rn.rn_src2_1        = src_q[1].tag;
  assign rn.rn_src1_2        = src_q[2].tag;
  assign rn.rn_src2_2        = src_q[3].tag;
  assign rn.rn_src1_1_mapped = src_q[0].valid;
  assign rn.rn_src2_1_mapped = src_q[1].valid;
  assign rn.rn_src1_2_mapped = src_q[2].valid;
  assign rn.rn_src2_2_mapped = src_q[3].valid;
  assign rn.rn_old1          = old_q[0].tag;
  assign rn.rn_old2          = old_q[1].tag;
  assign rn.rn_old1_valid    = old_q[0].valid;
  assign rn.rn_old2_valid    = old_q[1].valid;
endmodule

// File: doc/rename_table.md
RENAME_TABLE -- requirements
Module: rename_table

Interface
REQ-001 SHALL use parameters/macros `REG_NUM` (32 architectural registers), `REG_SEL` (5), and `PHY_REG_NUM`/`PHY_REG_SEL` from constants.vh.
REQ-002 SHALL have ports: clk input 1 (the single clock); reset input 1 (asynchronous, active-high).
REQ-003 SHALL have inputs invalid1, invalid2, wr_reg_1, wr_reg_2 (1 each): slot-invalid and slot-writes-register flags, with the same meaning as at the freelist.
REQ-004 SHALL have inputs src1_1, src2_1, src1_2, src2_2 [REG_SEL]: architectural sources for slot 1 and slot 2.
REQ-005 SHALL have inputs dst1, dst2 [REG_SEL]: architectural destinations.
REQ-006 SHALL have inputs phy_dst1, phy_dst2 [PHY_REG_SEL], phy_dst1_valid, phy_dst2_valid, and allocatable, all driven by the freelist.
REQ-007 SHALL have inputs stall_DP and prmiss (1 each).
REQ-008 SHALL have commit inputs com_valid1, com_valid2 (1 each), com_dst1, com_dst2 [REG_SEL], and com_phy1, com_phy2 [PHY_REG_SEL].
REQ-009 SHALL have registered outputs rn_valid1, rn_valid2 (1 each) and rn_phy_dst1, rn_phy_dst2 [PHY_REG_SEL].
REQ-010 SHALL have registered source outputs rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2 [PHY_REG_SEL], each with a *_mapped flag (1 = in physical register file, 0 = read from ARF).
REQ-011 SHALL have registered outputs rn_old1, rn_old2 [PHY_REG_SEL] with rn_old1_valid and rn_old2_valid: the previous mapping, sent to the ROB for later release.

Function
REQ-012 SHALL hold a speculative map (SM) and a committed map (CM), each REG_NUM entries of {valid, tag}.
REQ-013 SHALL define fire = allocatable & ~stall_DP & ~prmiss.
REQ-014 On posedge clk with fire: SM SHALL update from phy_dst1/2, and outputs SHALL load the renamed bundle (1-cycle latency).
REQ-015 SHALL update SM entry dstN only when phy_dstN_valid; wr_reg_N=0 or invalidN=1 SHALL leave SM unchanged and set rn_validN=0.
REQ-016 SHALL resolve slot-2 source equal to dst1 (slot 1 writing) to phy_dst1 with mapped=1, bypassing SM.
REQ-017 SHALL resolve slot-2 old mapping, when dst2==dst1 and slot 1 writes, to phy_dst1 with valid=1.
REQ-018 When both slots write the same architectural register, the SM final value SHALL be phy_dst2.
REQ-019 When stall_DP=1, all outputs and SM SHALL hold.
REQ-020 When ~allocatable & ~stall_DP, SHALL clear rn_valid1/2 (bubble) and leave SM unchanged.
REQ-021 On each posedge, com_validN SHALL write CM[com_dstN]={1,com_phyN}, independent of fire and stall_DP.
REQ-022 When both commit slots write the same architectural register, slot 2 SHALL win.
REQ-023 On prmiss: SM SHALL be set to CM including same-cycle commits, rn_valid1/2 SHALL be cleared, and no rename SHALL occur.
REQ-024 SHALL read sources from SM state before the current cycle's write.

Reset
REQ-025 Asynchronous reset SHALL clear all SM/CM valid bits (tags 0) and all output registers to 0, consistent with the freelist marking every physical tag free.
REQ-026 Reset asserted mid-bundle SHALL discard the bundle; the first fire after deassertion SHALL see empty maps.

Structure
REQ-027 `REG_NUM` and `REG_SEL` SHALL reside in constants.vh alongside the PHY_REG_* macros.
REQ-028 SHALL use one sub-module, rename_map_bank (REG_NUM×{valid,tag}, 4 read ports, 2 write ports with port-2 priority, parallel-load input), instantiated twice: once for SM, once for CM.
REQ-029 Total RTL SHALL be about 200–300 lines.

Verification
REQ-030 After reset, rename r3←p5 (slot 1), src r3 in slot 2 -> slot 2 rn_src mapped=1, tag=5; rn_old1_valid=0.
REQ-031 Next cycle, r3←p9 -> rn_old1=5, valid=1; subsequent read of r3 -> tag 9.
REQ-032 Both slots write r7 (p2, p4) -> rn_old2=2; later read of r7 -> 4.
REQ-033 stall_DP held 3 cycles mid-stream -> outputs unchanged, SM unchanged; allocatable=0 without stall -> rn_valid=0.
REQ-034 Commit r3→p5, speculative r3→p9, then prmiss with same-cycle commit r4→p6 -> reads r3=5, r4=6, others per CM.
REQ-035 Assert reset asynchronously between clock edges during a fire -> all outputs 0 immediately; all sources mapped=0.
